// File: rtl/riscv_regdump_unit.sv
// Run-control and register-dump engine: runs the core for a bounded number of cycles,
// then stalls it and streams a range of architectural registers over valid/ready.
module riscv_regdump_unit #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int FIRST_REG      = 1,
  parameter int LAST_REG       = 6,
  parameter int TIMEOUT_CYCLES = 55,
  parameter int CNT_W          = 16,
  localparam int IDX_W         = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  output logic             core_stall,
  output logic [IDX_W-1:0] dbg_raddr,
  input  logic [XLEN-1:0]  dbg_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]  dump_data,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] FIRST_IDX    = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(LAST_REG);
  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic             trigger;
  logic             beat_taken;
  logic             last_beat;

  always_comb begin
    trigger    = halt_req || (TIMEOUT_EN && (cycle_count == TIMEOUT_LAST));
    beat_taken = dump_valid && dump_ready;
    last_beat  = (idx == LAST_IDX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_RUN;
      S_RUN:   if (trigger)    state_d = S_READ;
      S_READ:                  state_d = S_SEND;
      S_SEND:  if (beat_taken) state_d = last_beat ? S_DONE : S_READ;
      S_DONE:  if (start)      state_d = S_RUN;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_READ) || (state_q == S_SEND);
    done = (state_q == S_DONE);
  end

  // Registered outputs and the dump cursor; the trigger cycle itself is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_stall  <= 1'b1;
      dbg_raddr   <= '0;
      dump_valid  <= 1'b0;
      dump_idx    <= '0;
      dump_data   <= '0;
      cycle_count <= '0;
      idx         <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cycle_count <= '0;
            core_stall  <= 1'b0;
          end
        end
        S_RUN: begin
          if (trigger) begin
            core_stall <= 1'b1;
            idx        <= FIRST_IDX;
            dbg_raddr  <= FIRST_IDX;
          end else if (cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        S_READ: begin
          dump_data  <= (idx == '0) ? '0 : dbg_rdata;
          dump_idx   <= idx;
          dump_valid <= 1'b1;
        end
        S_SEND: begin
          if (beat_taken) begin
            dump_valid <= 1'b0;
            if (!last_beat) begin
              idx       <= idx + IDX_W'(1);
              dbg_raddr <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
